// File: rtl/alu_result_framer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_framer
// Purpose  : Captures an ALU result and offers it to the UART TX one byte at a
//            time, LSB first. Define RESULT_TRIM_EN to skip leading zero bytes.
// Revision : 1.0
// ============================================================================
module alu_result_framer #(
    parameter int RESULT_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [RESULT_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    TX_BUSY,
    output logic [7:0]              TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    BUSY,
    output logic                    DROP
);

    localparam int NUM_BYTES = RESULT_WIDTH / 8;
    localparam int c_cnt_w   = $clog2(NUM_BYTES + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_all = c_cnt_w'(NUM_BYTES);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_wait = 2'd1;
    localparam logic [1:0] c_s_send = 2'd2;

    generate
        if ((RESULT_WIDTH % 8) != 0 || RESULT_WIDTH < 8 || RESULT_WIDTH > 32) begin : g_bad_width
            $error("alu_result_framer: RESULT_WIDTH must be a multiple of 8 in 8..32");
        end
    endgenerate

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [RESULT_WIDTH-1:0] r_shadow;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      r_tot;
    logic [c_cnt_w-1:0]      w_tot_cap;
    logic [RESULT_WIDTH-1:0] w_shifted;
    logic [7:0]              w_cur_byte;

    logic [7:0]              r_tx_p_data;
    logic                    r_tx_d_vld;
    logic                    r_busy;
    logic                    r_drop;
    logic [7:0]              w_tx_p_data_nxt;
    logic                    w_tx_d_vld_nxt;
    logic                    w_busy_nxt;
    logic                    w_drop_nxt;

    logic                    w_capture;
    logic                    w_advance;

    assign w_capture = (r_state == c_s_idle) && OUT_VALID;
    assign w_advance = (r_state == c_s_send) && TX_BUSY;

    // Number of bytes to frame for the result being captured this cycle.
    always_comb begin
        w_tot_cap = c_cnt_all;
`ifdef RESULT_TRIM_EN
        w_tot_cap = c_cnt_one;
        for (int i = 1; i < NUM_BYTES; i++) begin
            if (ALU_OUT[8*i +: 8] != 8'h00) begin
                w_tot_cap = c_cnt_w'(i + 1);
            end
        end
`endif
    end

    assign w_shifted  = r_shadow >> {r_cnt, 3'b000};
    assign w_cur_byte = w_shifted[7:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: begin
                if (OUT_VALID) begin
                    w_state_nxt = c_s_wait;
                end
            end
            c_s_wait: begin
                // A busy TX (ours or a stale one) is always waited out here.
                if (!TX_BUSY) begin
                    w_state_nxt = (r_cnt == r_tot) ? c_s_idle : c_s_send;
                end
            end
            c_s_send: begin
                if (TX_BUSY) begin
                    w_state_nxt = c_s_wait;
                end
            end
            default: w_state_nxt = c_s_idle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_tot    <= '0;
        end else if (w_capture) begin
            r_shadow <= ALU_OUT;
            r_cnt    <= '0;
            r_tot    <= w_tot_cap;
        end else if (w_advance) begin
            r_cnt    <= r_cnt + c_cnt_one;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_tx_d_vld_nxt  = (w_state_nxt == c_s_send);
        w_tx_p_data_nxt = r_tx_p_data;
        if (w_state_nxt == c_s_send) begin
            w_tx_p_data_nxt = w_cur_byte;
        end
        w_busy_nxt = (w_state_nxt != c_s_idle);
        w_drop_nxt = OUT_VALID && (r_state != c_s_idle);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx_p_data <= 8'h00;
            r_tx_d_vld  <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_tx_p_data <= w_tx_p_data_nxt;
            r_tx_d_vld  <= w_tx_d_vld_nxt;
            r_busy      <= w_busy_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign TX_P_DATA = r_tx_p_data;
    assign TX_D_VLD  = r_tx_d_vld;
    assign BUSY      = r_busy;
    assign DROP      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_framer
// Purpose  : Self-checking bench for alu_result_framer with a UART TX model.
// Revision : 1.0
// ============================================================================
module tb_alu_result_framer;

    localparam int W  = 16;
    localparam int NB = W / 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] ALU_OUT;
    logic         OUT_VALID;
    logic         TX_BUSY;
    logic [7:0]   TX_P_DATA;
    logic         TX_D_VLD;
    logic         BUSY;
    logic         DROP;

    int n_assert = 0;
    int n_fail   = 0;

    int accept_delay = 0;
    int busy_len     = 3;
    int stale_len    = 0;
    int model_err    = 0;
    int vld_rises    = 0;
    int m_state      = 0;
    int m_cnt        = 0;
    logic       prev_vld  = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];

    alu_result_framer #(.RESULT_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID),
        .TX_BUSY   (TX_BUSY),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .BUSY      (BUSY),
        .DROP      (DROP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_accept;
        sent_q.push_back(TX_P_DATA);
        TX_BUSY = 1'b1;
        m_cnt   = busy_len;
        m_state = 2;
    endtask

    // UART TX model: accepts an offered byte after accept_delay cycles,
    // stays busy for busy_len cycles, and polices the offer protocol.
    initial begin
        TX_BUSY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                TX_BUSY   = 1'b0;
                m_state   = 0;
                prev_vld  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (TX_D_VLD && !prev_vld) vld_rises++;
                if (TX_D_VLD && prev_busy) model_err++;
                if (prev_vld && TX_D_VLD && TX_P_DATA != prev_data) model_err++;
                if (prev_vld && !TX_D_VLD && !prev_busy) model_err++;
                prev_vld  = TX_D_VLD;
                prev_data = TX_P_DATA;
                case (m_state)
                    0: begin
                        if (stale_len > 0) begin
                            TX_BUSY   = 1'b1;
                            m_cnt     = stale_len;
                            stale_len = 0;
                            m_state   = 2;
                        end else if (TX_D_VLD) begin
                            if (accept_delay == 0) begin
                                do_accept();
                            end else begin
                                m_cnt   = accept_delay;
                                m_state = 1;
                            end
                        end
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) do_accept();
                    end
                    default: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            TX_BUSY = 1'b0;
                            m_state = 0;
                        end
                    end
                endcase
                prev_busy = TX_BUSY;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: bytes that should reach the TX for a captured result.
    task automatic build_expected(input logic [W-1:0] v);
        int           tot;
        logic [W-1:0] t;
        exp_q.delete();
        tot = NB;
`ifdef RESULT_TRIM_EN
        tot = 1;
        for (int i = 0; i < NB; i++) begin
            if (((v >> (8 * i)) & W'(8'hFF)) != '0) tot = i + 1;
        end
`endif
        t = v;
        for (int i = 0; i < tot; i++) begin
            exp_q.push_back(t[7:0]);
            t = t >> 8;
        end
    endtask

    task automatic pulse(input logic [W-1:0] v);
        @(negedge CLK);
        ALU_OUT   = v;
        OUT_VALID = 1'b1;
        @(negedge CLK);
        OUT_VALID = 1'b0;
        ALU_OUT   = W'($urandom);
    endtask

    task automatic wait_frame_done(input string tag);
        logic pb, pt, pt2;
        bit   done;
        pb   = BUSY;
        pt   = TX_BUSY;
        pt2  = TX_BUSY;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge CLK);
            if (pb && !BUSY) begin
                check({tag, "_busy_fall"}, {30'd0, pt2, pt}, 32'd2);
                done = 1'b1;
            end
            pt2 = pt;
            pt  = TX_BUSY;
            pb  = BUSY;
        end
        if (!done) check({tag, "_timeout"}, {31'd0, BUSY}, 32'd0);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_count"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, sent_q[i]}, {24'd0, exp_q[i]});
        end
        check({tag, "_vld_pulses"}, vld_rises, exp_q.size());
        check({tag, "_protocol"}, model_err, 0);
        sent_q.delete();
        vld_rises = 0;
        model_err = 0;
    endtask

    initial begin
        logic [W-1:0] v;
        bit           seen_vld;
        int           guard;

        RST       = 1'b0;
        OUT_VALID = 1'b0;
        ALU_OUT   = '0;
        repeat (3) @(negedge CLK);
        check("rst_data", {24'd0, TX_P_DATA}, 32'h00);
        check("rst_vld",  {31'd0, TX_D_VLD}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_drop", {31'd0, DROP}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // 0x1234 with a slow TX, plus capture-to-offer latency.
        accept_delay = 1;
        busy_len     = 10;
        @(negedge CLK);
        ALU_OUT   = 16'h1234;
        OUT_VALID = 1'b1;
        @(negedge CLK);
        OUT_VALID = 1'b0;
        check("lat_busy", {31'd0, BUSY}, 32'd1);
        check("lat_vld_early", {31'd0, TX_D_VLD}, 32'd0);
        @(negedge CLK);
        check("lat_vld", {31'd0, TX_D_VLD}, 32'd1);
        check("lat_byte0", {24'd0, TX_P_DATA}, 32'h34);
        wait_frame_done("f1234");
        build_expected(16'h1234);
        compare_frame("f1234");

        busy_len = 3;
        pulse(16'h0034);
        wait_frame_done("f0034");
        build_expected(16'h0034);
        compare_frame("f0034");

        pulse(16'h0000);
        wait_frame_done("f0000");
        build_expected(16'h0000);
        compare_frame("f0000");

        // A second result arriving mid-frame is dropped.
        busy_len = 10;
        pulse(16'h1234);
        repeat (3) @(negedge CLK);
        ALU_OUT   = 16'hBEEF;
        OUT_VALID = 1'b1;
        @(negedge CLK);
        OUT_VALID = 1'b0;
        check("drop_pulse", {31'd0, DROP}, 32'd1);
        check("drop_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check("drop_clear", {31'd0, DROP}, 32'd0);
        wait_frame_done("fdrop");
        build_expected(16'h1234);
        compare_frame("fdrop");

        // TX still busy with another source's byte at capture.
        busy_len  = 3;
        stale_len = 5;
        pulse(16'h00AB);
        guard = 0;
        while (TX_BUSY && guard < 20) begin
            check("stale_no_vld", {31'd0, TX_D_VLD}, 32'd0);
            @(negedge CLK);
            guard++;
        end
        wait_frame_done("fstale");
        build_expected(16'h00AB);
        compare_frame("fstale");

        // Reset while byte 0 is pending in SEND.
        accept_delay = 20;
        pulse(16'h1234);
        guard = 0;
        while (!TX_D_VLD && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        check("mid_rst_offer", {31'd0, TX_D_VLD}, 32'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_data", {24'd0, TX_P_DATA}, 32'h00);
        check("mid_rst_vld",  {31'd0, TX_D_VLD}, 32'd0);
        check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        check("mid_rst_drop", {31'd0, DROP}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        seen_vld = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (TX_D_VLD) seen_vld = 1'b1;
        end
        check("post_rst_no_vld", {31'd0, seen_vld}, 32'd0);
        check("post_rst_no_bytes", sent_q.size(), 0);
        sent_q.delete();
        vld_rises    = 0;
        model_err    = 0;
        accept_delay = 2;
        pulse(16'h5566);
        wait_frame_done("f5566");
        build_expected(16'h5566);
        compare_frame("f5566");

        // TX acceptance delayed 7 cycles: offer must hold steady.
        accept_delay = 7;
        pulse(16'hA5C3);
        wait_frame_done("fdelay");
        build_expected(16'hA5C3);
        compare_frame("fdelay");

        for (int it = 0; it < 24; it++) begin
            v = W'($urandom);
            if ($urandom_range(0, 2) == 0) v[W-1:8] = '0;
            if ($urandom_range(0, 5) == 0) v = '0;
            accept_delay = $urandom_range(0, 4);
            busy_len     = $urandom_range(1, 6);
            pulse(v);
            if ($urandom_range(0, 1) == 1) begin
                ALU_OUT   = W'($urandom);
                OUT_VALID = 1'b1;
                @(negedge CLK);
                OUT_VALID = 1'b0;
                check($sformatf("rnd%0d_drop", it), {31'd0, DROP}, 32'd1);
            end
            wait_frame_done($sformatf("rnd%0d", it));
            build_expected(v);
            compare_frame($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_framer.md
# alu_result_framer

Return path from the ALU to the UART transmitter. Captures a wide ALU result on its one-cycle valid pulse, splits it into bytes and hands them to the UART TX one at a time, LSB byte first, via a valid/busy handshake. Sits between the ALU output register and the UART TX parallel input, and reports its own busy status back to the system controller.

## Interface
- RESULT_WIDTH, 16: ALU result width; must be a multiple of 8, range 8..32.
- NUM_BYTES, RESULT_WIDTH/8: bytes per frame (derived; do not override).
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- ALU_OUT  input  RESULT_WIDTH  ALU result; sampled only when OUT_VALID=1.
- OUT_VALID  input  1  one-cycle pulse, ALU_OUT valid.
- TX_BUSY  input  1  UART TX busy; rises when a byte is accepted, falls when the frame is done.
- TX_P_DATA  output  8  byte offered to UART TX.
- TX_D_VLD  output  1  TX_P_DATA valid.
- BUSY  output  1  framer holds an unsent or in-flight result.
- DROP  output  1  one-cycle pulse, OUT_VALID arrived while BUSY=1; that result is discarded.

## Operation
- States: IDLE, WAIT, SEND. Registers: shadow result (RESULT_WIDTH), byte counter cnt (sent bytes), total byte count tot.
- IDLE: OUT_VALID=1 -> shadow <= ALU_OUT, cnt <= 0, tot computed (see Configuration), -> WAIT.
- WAIT: TX_BUSY=0 and cnt==tot -> IDLE; TX_BUSY=0 and cnt<tot -> SEND. TX_BUSY=1 -> stay.
- SEND: TX_D_VLD=1, TX_P_DATA = shadow[8*cnt+7 : 8*cnt]. TX_BUSY=1 -> cnt <= cnt+1, -> WAIT. Otherwise hold data and valid stable.
- BUSY = (state != IDLE).
- OUT_VALID while state != IDLE: ignored, shadow unchanged, DROP=1 next cycle for one cycle. Only accepted in IDLE, including the cycle the FSM returns to IDLE.
- A stale TX_BUSY=1 at capture (TX still sending another source's byte) is absorbed by WAIT; no byte is offered until TX_BUSY=0.
- Reset (any time, including mid-frame): state IDLE, cnt 0, shadow 0, all outputs 0; in-flight frame abandoned, no further bytes offered.

## Timing
- Outputs registered. Reset values: TX_P_DATA=0x00, TX_D_VLD=0, BUSY=0, DROP=0.
- OUT_VALID sampled at edge N (IDLE) -> BUSY=1 from N+1; with TX_BUSY=0, TX_D_VLD=1 and byte 0 from N+2.
- TX_D_VLD falls the cycle after TX_BUSY is seen high in SEND; next byte offered earliest 2 cycles after TX_BUSY falls.
- After the last byte: BUSY falls the cycle after TX_BUSY=0 is seen in WAIT.
- TX_P_DATA holds its last value when TX_D_VLD=0.

## Configuration
- RESULT_TRIM_EN defined: tot = 1 + index of highest nonzero byte of ALU_OUT; leading zero bytes are not sent; ALU_OUT=0 sends exactly one byte 0x00.
- RESULT_TRIM_EN undefined: tot = NUM_BYTES always; every byte sent, zeros included.

## Test plan
- RESULT_WIDTH=16, ALU_OUT=0x1234 pulse, TX model busy 10 cycles per byte -> TX_P_DATA 0x34 then 0x12, two TX_D_VLD handshakes, BUSY falls after second TX_BUSY fall.
- ALU_OUT=0x0034: without RESULT_TRIM_EN -> 0x34, 0x00; with RESULT_TRIM_EN -> only 0x34. ALU_OUT=0x0000 with RESULT_TRIM_EN -> single 0x00.
- Second OUT_VALID (0xBEEF) during first frame (0x1234) -> DROP one cycle, bytes still 0x34, 0x12, 0xBEEF never sent.
- TX_BUSY held high 5 cycles at capture of 0x00AB -> TX_D_VLD stays 0 until TX_BUSY=0, then 0xAB sent.
- RST low while in SEND with byte 0 pending -> all outputs 0 immediately, no bytes after release; next OUT_VALID 0x5566 framed normally as 0x66, 0x55.
- TX_BUSY rise delayed 7 cycles in SEND -> TX_D_VLD and TX_P_DATA stable all 7 cycles, cnt advances exactly once.
